// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the CPU memory stage
// (master) and the data memory responder (slave).
// Optional byte strobes appear when MEM_RESPONDER_BYTE_STROBE_EN is defined.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
    logic [3:0]  req_be;
`endif
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
        output req_be,
`endif
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
        input  req_be,
`endif
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed data memory with a valid/ready request
// channel, LATENCY wait cycles, and a single-cycle response strobe.
// Optional feature macro: MEM_RESPONDER_BYTE_STROBE_EN (per-byte write strobes).
// Memory contents are deliberately not reset; only control/response state is.
module mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        commit;
    logic        accept;

    // Captured request
    logic           we_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
    logic [3:0]     be_q;
`endif

    // Response registers
    logic [31:0] rdata_q;
    logic        err_q;

    // Commit-time view of the transaction
    logic           c_we;
    logic [AW+1:0]  c_addr;
    logic [31:0]    c_wdata;
    logic [3:0]     c_be;
    logic           c_mis;
    logic [AW-1:0]  c_idx;
    logic           wr_en;

    logic [31:0] mem [DEPTH];

    // Upper address bits alias and are intentionally discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr;

    assign accept         = (state_q == IDLE) && bus.req_valid;
    // Ready drops combinationally with reset so nothing is offered mid-reset.
    assign bus.req_ready  = (state_q == IDLE) && !reset;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Next-state and commit decision
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    cnt_d = LATENCY[3:0];
                    if (LATENCY == 0) begin
                        // Zero wait: commit on the accept edge itself.
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Select live request (zero-latency commit in IDLE) or captured request
    always_comb begin
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
        c_be    = be_q;
`else
        c_be    = 4'b1111;
`endif
        if (state_q == IDLE) begin
            c_we    = bus.req_we;
            c_addr  = bus.req_addr[AW+1:0];
            c_wdata = bus.req_wdata;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
            c_be    = bus.req_be;
`endif
        end
    end

    assign c_mis = (c_addr[1:0] != 2'b00);
    assign c_idx = c_addr[AW+1:2];
    // Reset on the commit edge suppresses the write.
    assign wr_en = commit && c_we && !c_mis && !reset;

    // Control state, request capture and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
            be_q    <= 4'd0;
`endif
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr[AW+1:0];
                wdata_q <= bus.req_wdata;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
                be_q    <= bus.req_be;
`endif
            end
            if (commit) begin
                err_q <= c_mis;
                if (!c_we && !c_mis) begin
                    rdata_q <= mem[c_idx];
                end else begin
                    rdata_q <= 32'd0;
                end
            end
        end
    end

    // Memory array write port with per-byte enables
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (c_be[b]) begin
                    mem[c_idx][b*8 +: 8] <= c_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed-vector bench for mem_responder using a
// LATENCY=2 instance for most cases and a LATENCY=0 instance for
// back-to-back handshaking.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_responder_if bus2();
    mem_responder_if bus0();

    mem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    mem_responder #(.DEPTH(1024), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One transaction on the LATENCY=2 instance, checking latency and response.
    task automatic txn2(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int k;
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, bus2.req_ready}, 32'd1);
        bus2.req_valid = 1'b1;
        bus2.req_we    = we;
        bus2.req_addr  = addr;
        bus2.req_wdata = wdata;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
        bus2.req_be    = be;
`endif
        @(negedge clk);
        bus2.req_valid = 1'b0;
        k = 1;
        while (!bus2.resp_valid && k < 16) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, k, 32'd3);
        check({tag, "_rdata"}, bus2.resp_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, bus2.resp_err}, {31'd0, exp_err});
        @(negedge clk);
        check({tag, "_oneshot"}, {31'd0, bus2.resp_valid}, 32'd0);
        check({tag, "_hold"}, bus2.resp_rdata, exp_rdata);
    endtask

    // Held-valid stream on the LATENCY=0 instance
    logic        s_we    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] s_addr  [4] = '{32'h4, 32'h8, 32'h4, 32'h8};
    logic [31:0] s_wdata [4] = '{32'h0000_1111, 32'h0000_2222, 32'h0, 32'h0};
    logic [31:0] s_exp   [4] = '{32'h0, 32'h0, 32'h0000_1111, 32'h0000_2222};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_resp;
        reset = 1'b1;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
        bus2.req_be = 4'hF;
        bus0.req_be = 4'hF;
`endif
        repeat (3) @(negedge clk);
        check("rst_ready",  {31'd0, bus2.req_ready},  32'd0);
        check("rst_rvalid", {31'd0, bus2.resp_valid}, 32'd0);
        check("rst_rdata",  bus2.resp_rdata,          32'd0);
        check("rst_err",    {31'd0, bus2.resp_err},   32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, bus2.req_ready}, 32'd1);

        // Basic write then read
        txn2("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        txn2("rd10", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);

        // Misaligned write must not disturb memory
        txn2("wr13_mis", 1'b1, 32'h13, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
        txn2("rd10_again", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
        txn2("rd12_mis", 1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1);

        // Aliasing modulo DEPTH*4
        txn2("wr0", 1'b1, 32'h0, 32'hAAAA_5555, 4'hF, 32'h0, 1'b0);
        txn2("rd1000_alias", 1'b0, 32'h1000, 32'h0, 4'hF, 32'hAAAA_5555, 1'b0);

        // Reset during WAIT drops the transaction
        txn2("wr20_init", 1'b1, 32'h20, 32'hCAFE_0000, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b1;
        bus2.req_addr = 32'h20; bus2.req_wdata = 32'h1;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_wait_ready", {31'd0, bus2.req_ready}, 32'd0);
        @(negedge clk);
        check("rst_wait_rvalid", {31'd0, bus2.resp_valid}, 32'd0);
        reset = 1'b0;
        saw_resp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus2.resp_valid) saw_resp = 1'b1;
        end
        check("rst_wait_noresp", {31'd0, saw_resp}, 32'd0);
        txn2("rd20_after_rst", 1'b0, 32'h20, 32'h0, 4'hF, 32'hCAFE_0000, 1'b0);

`ifdef MEM_RESPONDER_BYTE_STROBE_EN
        txn2("be_full", 1'b1, 32'h30, 32'h1122_3344, 4'b1111, 32'h0, 1'b0);
        txn2("be_0101", 1'b1, 32'h30, 32'hFFFF_FFFF, 4'b0101, 32'h0, 1'b0);
        txn2("be_rd",   1'b0, 32'h30, 32'h0, 4'b0000, 32'h11FF_33FF, 1'b0);
        txn2("be_none", 1'b1, 32'h30, 32'h0, 4'b0000, 32'h0, 1'b0);
        txn2("be_rd2",  1'b0, 32'h30, 32'h0, 4'b1010, 32'h11FF_33FF, 1'b0);
`endif

        // LATENCY=0 instance: valid held high, ready toggles 1,0,1,0,...
        @(negedge clk);
        bus0.req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                check($sformatf("l0_ready%0d", i), {31'd0, bus0.req_ready}, 32'd1);
                check($sformatf("l0_rvalid%0d", i), {31'd0, bus0.resp_valid}, 32'd0);
                bus0.req_we    = s_we[i/2];
                bus0.req_addr  = s_addr[i/2];
                bus0.req_wdata = s_wdata[i/2];
            end else begin
                check($sformatf("l0_ready%0d", i), {31'd0, bus0.req_ready}, 32'd0);
                check($sformatf("l0_rvalid%0d", i), {31'd0, bus0.resp_valid}, 32'd1);
                check($sformatf("l0_rdata%0d", i), bus0.resp_rdata, s_exp[i/2]);
            end
            @(negedge clk);
        end
        bus0.req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed data memory with a valid/ready request channel and a one-shot response, acting as the responder side of the multi-cycle CPU's memory-access path. It accepts one read or write per transaction, inserts a configurable number of wait cycles, then returns read data or a write acknowledge. The CPU control FSM holds in its memory state until `resp_valid`. This block replaces the zero-latency combinational data memory.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two.
- `LATENCY`, 2: wait cycles between accept and commit; 0..15.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `resp_valid`  out  1  single-cycle response strobe.
- `resp_rdata`  out  32  read data; 0 for writes and errors.
- `resp_err`  out  1  misaligned access; valid with `resp_valid`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, capture `req_we`, `req_addr` and `req_wdata`, and load the wait counter with `LATENCY`.
  - Next state is WAIT if `LATENCY` > 0.
  - Otherwise the commit happens at the accept edge and the next state is RESP.
- WAIT: `req_ready`=0. The counter decrements each cycle. When it reaches 1, the commit happens at that edge and the FSM moves to RESP.
- Commit, for an aligned access:
  - Write: the word is stored and `resp_rdata` is loaded with 0.
  - Read: `resp_rdata` is loaded with the stored word.
- Misaligned access (`req_addr[1:0]` != 0): nothing is written, `resp_rdata` is 0 and `resp_err` is 1.
- RESP: `resp_valid`=1 and `req_ready`=0 for exactly one cycle, then the FSM returns to IDLE.
  - The response has no backpressure; the requester must sample it in that cycle.
- Word index is `req_addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses alias modulo DEPTH*4.
- Request inputs are ignored outside IDLE. A `req_valid` held through WAIT/RESP is not a new request until the FSM is back in IDLE.

## Timing
- Reset values: state IDLE, `req_ready`=0 while `reset` is high and 1 in the first cycle after, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter 0.
- Memory array contents are not affected by reset.
- Latency: accept edge to the `resp_valid` cycle is LATENCY+1 cycles. Initiation interval is LATENCY+2 cycles.
- `resp_rdata` and `resp_err` hold their values after RESP until the next commit.
- Reset asserted in WAIT: the transaction is dropped, no write occurs and no response is issued.
- Reset asserted on the commit edge: reset wins and nothing is written.
- Reset asserted in RESP: `resp_valid` is 0 in the following cycle.
- Read immediately after a write to the same word returns the new data, since the commit precedes the next accept.

## Configuration
- `MEM_RESPONDER_BYTE_STROBE_EN` defined:
  - Adds input `req_be` [3:0], captured at accept.
  - On a write, only bytes with `req_be[i]`=1 are updated; the other bytes are unchanged.
  - `req_be`=0000 writes nothing but still responds normally.
  - Reads ignore `req_be`.
- Not defined: the `req_be` port is absent and every write updates the full word.

## Test plan
- Reset, then LATENCY=2: write 0xDEADBEEF to 0x10, then read 0x10.
  - `resp_valid` appears 3 cycles after each accept.
  - Read returns 0xDEADBEEF with `resp_err`=0.
- LATENCY=0: back-to-back reads with `req_valid` held high. Responses are one cycle after each accept, and `req_ready` toggles 1,0,1,0.
- Misaligned write to 0x13 with data 0x12345678: `resp_err`=1 and `resp_rdata`=0. A subsequent read of 0x10 returns its previous value.
- Write 0xAAAA5555 to 0x0, then read 0x1000 with DEPTH=1024 (aliasing): returns 0xAAAA5555.
- Accept a write of 0x1 to 0x20, assert `reset` in the first WAIT cycle, then read 0x20: no response is ever issued for the write, and the read returns the old contents.
- With `MEM_RESPONDER_BYTE_STROBE_EN`: write 0x11223344 full-word, then write 0xFFFFFFFF with `req_be`=0101. Read returns 0x11FF33FF.
